// File: rtl/keypad_scan_if.sv
// keypad_scan_if: key matrix drive/sense and decoded key outputs of keypad_scan.
interface keypad_scan_if;
    logic [3:0]  COL;
    logic        clr;
    logic [3:0]  ROW;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [15:0] num;
    modport master (output COL, clr, input ROW, key_code, key_valid, key_down, num);
    modport slave (input COL, clr, output ROW, key_code, key_valid, key_down, num);
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 matrix scanner with per-scan debounce, one code per press and
// a 4-digit shift register laid out like the display's num input.
module keypad_scan #(
    parameter int DIV_BITS       = 17,
    parameter int DEBOUNCE_SCANS = 4
) (
    input logic          clk_100mhz,
    input logic          RSTN,
    keypad_scan_if.slave kp
);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DEBOUNCE = 2'd1;
    localparam logic [1:0] PRESSED  = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;
    localparam logic [4:0] LAST     = 5'(DEBOUNCE_SCANS);
    logic [3:0]          col_s1, col_s2;
    logic [DIV_BITS-1:0] div;
    logic [1:0]          r, state, col_idx;
    logic [4:0]          cnt;
    logic [3:0]          cand, acc_code, code, key_code;
    logic [15:0]         num;
    logic                acc_found, found, hit, tick, eos, done, key_valid, key_down;
    assign tick    = &div;
    assign eos     = tick && r == 2'd3;
    assign hit     = ~&col_s2;
    assign col_idx = !col_s2[0] ? 2'd0 : !col_s2[1] ? 2'd1 : !col_s2[2] ? 2'd2 : 2'd3;
    // the row being sampled at end of scan still counts toward this scan's result
    assign found   = acc_found || hit;
    assign code    = acc_found ? acc_code : {r, col_idx};
    assign done    = cnt + 5'd1 == LAST;
    assign kp.ROW       = ~(4'b1 << r);
    assign kp.key_code  = key_code;
    assign kp.key_valid = key_valid;
    assign kp.key_down  = key_down;
    assign kp.num       = num;
    always_ff @(posedge clk_100mhz or negedge RSTN) begin
        if (!RSTN) begin
            col_s1    <= 4'hF;
            col_s2    <= 4'hF;
            div       <= '0;
            r         <= 2'd0;
            state     <= IDLE;
            cnt       <= 5'd0;
            cand      <= 4'd0;
            acc_found <= 1'b0;
            acc_code  <= 4'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            num       <= 16'h0;
        end else begin
            col_s1    <= kp.COL;
            col_s2    <= col_s1;
            div       <= div + 1'b1;
            key_valid <= 1'b0;
            if (tick) begin
                r <= r + 2'd1;
                if (eos) begin
                    acc_found <= 1'b0;
                    acc_code  <= 4'd0;
                end else if (!acc_found && hit) begin
                    acc_found <= 1'b1;
                    acc_code  <= {r, col_idx};
                end
            end
            if (eos) begin
                case (state)
                    IDLE: if (found) begin
                        cand  <= code;
                        cnt   <= 5'd1;
                        state <= DEBOUNCE;
                    end
                    DEBOUNCE: if (!found) state <= IDLE;
                    else if (code != cand) begin
                        cand <= code;
                        cnt  <= 5'd1;
                    end else begin
                        cnt <= cnt + 5'd1;
                        if (done) begin
                            key_code  <= cand;
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            num       <= {num[11:0], cand};
                            state     <= PRESSED;
                        end
                    end
                    PRESSED: if (!found) begin
                        cnt   <= 5'd1;
                        state <= RELEASE;
                    end
                    default: if (found) state <= PRESSED;
                    else begin
                        cnt <= cnt + 5'd1;
                        if (done) begin
                            key_down <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                endcase
            end
            if (kp.clr) num <= 16'h0;
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed keypad scenarios against a 4x4 matrix model; accepted
// presses are predicted into a queue and matched against every key_valid pulse.
module tb_keypad_scan;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [15:0] keys = 16'h0;
    logic [3:0]  col;
    logic [19:0] exp_q[$];
    logic [19:0] e;
    logic [15:0] model_num = 16'h0;
    logic        prev_valid = 1'b0;
    int          checks = 0, errors = 0, pulses = 0, exp_pulses = 0;

    keypad_scan_if kp();
    keypad_scan #(.DIV_BITS(2), .DEBOUNCE_SCANS(3)) dut (.clk_100mhz(clk), .RSTN(rstn), .kp(kp));

    always #5 clk = ~clk;

    // pressed key (r,c) pulls column c low while row r is driven low
    always_comb begin
        col = 4'hF;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (!kp.ROW[i] && keys[i*4+j]) col[j] = 1'b0;
    end
    assign kp.COL = col;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_key(input logic [3:0] c, input logic clr_hit);
        model_num = clr_hit ? 16'h0 : {model_num[11:0], c};
        exp_q.push_back({c, model_num});
        exp_pulses++;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // leaves the bench at the first negedge after row 0 of a new scan is driven
    task automatic next_scan_start();
        int n = 0;
        while (kp.ROW === 4'b1110 && n < 64) begin @(negedge clk); n++; end
        while (kp.ROW !== 4'b1110 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) begin
            checks++;
            errors++;
            $error("FAIL scan_align timeout ROW=%b expected=1110", kp.ROW);
        end
    endtask

    task automatic tap(input int k);
        next_scan_start();
        keys[k] = 1'b1;
        expect_key(4'(k), 1'b0);
        cycles(64);
        keys = 16'h0;
        cycles(64);
    endtask

    always @(negedge clk) begin
        if (kp.key_valid) begin
            pulses++;
            check("valid_width", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_pulse observed=%0h expected=none", kp.key_code);
            end else begin
                e = exp_q.pop_front();
                check("pulse_code", {28'd0, kp.key_code}, {28'd0, e[19:16]});
                check("pulse_num", {16'd0, kp.num}, {16'd0, e[15:0]});
            end
        end
        prev_valid <= kp.key_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        kp.clr = 1'b0;
        cycles(3);
        check("rst_row", {28'd0, kp.ROW}, 32'hE);
        check("rst_code", {28'd0, kp.key_code}, 32'd0);
        check("rst_valid", {31'd0, kp.key_valid}, 32'd0);
        check("rst_down", {31'd0, kp.key_down}, 32'd0);
        check("rst_num", {16'd0, kp.num}, 32'd0);
        rstn = 1'b1;
        // single press of (2,1)
        next_scan_start();
        keys[9] = 1'b1;
        expect_key(4'd9, 1'b0);
        cycles(47);
        check("press_down_early", {31'd0, kp.key_down}, 32'd0);
        cycles(1);
        check("press_down", {31'd0, kp.key_down}, 32'd1);
        check("press_valid", {31'd0, kp.key_valid}, 32'd1);
        cycles(160);
        check("hold_pulses", pulses, exp_pulses);
        check("hold_down", {31'd0, kp.key_down}, 32'd1);
        next_scan_start();
        keys = 16'h0;
        cycles(47);
        check("release_down_early", {31'd0, kp.key_down}, 32'd1);
        cycles(1);
        check("release_down", {31'd0, kp.key_down}, 32'd0);
        // digit entry
        for (int k = 1; k <= 5; k++) tap(k);
        check("digits_num", {16'd0, kp.num}, 32'h2345);
        check("digits_pulses", pulses, exp_pulses);
        // bounce on (0,0)
        next_scan_start();
        keys[0] = 1'b1;
        cycles(16);
        keys = 16'h0;
        cycles(16);
        keys[0] = 1'b1;
        cycles(16);
        keys = 16'h0;
        cycles(80);
        check("bounce_pulses", pulses, exp_pulses);
        check("bounce_down", {31'd0, kp.key_down}, 32'd0);
        // candidate switch 3 -> 6
        next_scan_start();
        keys[3] = 1'b1;
        cycles(32);
        keys = 16'h0;
        keys[6] = 1'b1;
        expect_key(4'd6, 1'b0);
        cycles(47);
        check("switch_down_early", {31'd0, kp.key_down}, 32'd0);
        cycles(1);
        check("switch_down", {31'd0, kp.key_down}, 32'd1);
        check("switch_code", {28'd0, kp.key_code}, 32'd6);
        keys = 16'h0;
        cycles(64);
        // simultaneous (1,3)+(2,0), then add (0,1) while pressed
        next_scan_start();
        keys[7] = 1'b1;
        keys[8] = 1'b1;
        expect_key(4'd7, 1'b0);
        cycles(64);
        check("multi_code", {28'd0, kp.key_code}, 32'd7);
        keys[1] = 1'b1;
        cycles(80);
        check("multi_pulses", pulses, exp_pulses);
        check("multi_code_held", {28'd0, kp.key_code}, 32'd7);
        check("multi_down", {31'd0, kp.key_down}, 32'd1);
        keys = 16'h0;
        cycles(64);
        check("multi_release", {31'd0, kp.key_down}, 32'd0);
        // clr while idle
        check("pre_clr_num", {16'd0, kp.num}, {16'd0, model_num});
        kp.clr = 1'b1;
        cycles(1);
        kp.clr = 1'b0;
        model_num = 16'h0;
        check("clr_idle_num", {16'd0, kp.num}, 32'd0);
        tap(5);
        check("after_clr_num", {16'd0, kp.num}, 32'h0005);
        // clr coinciding with acceptance of key A
        next_scan_start();
        keys[10] = 1'b1;
        expect_key(4'hA, 1'b1);
        cycles(47);
        kp.clr = 1'b1;
        cycles(1);
        kp.clr = 1'b0;
        check("clr_acc_num", {16'd0, kp.num}, 32'd0);
        check("clr_acc_code", {28'd0, kp.key_code}, 32'hA);
        check("clr_acc_valid", {31'd0, kp.key_valid}, 32'd1);
        keys = 16'h0;
        cycles(64);
        // async reset in DEBOUNCE with key 3 held
        tap(4);
        next_scan_start();
        keys[3] = 1'b1;
        cycles(24);
        #3 rstn = 1'b0;
        #1;
        check("arst_row", {28'd0, kp.ROW}, 32'hE);
        check("arst_code", {28'd0, kp.key_code}, 32'd0);
        check("arst_valid", {31'd0, kp.key_valid}, 32'd0);
        check("arst_down", {31'd0, kp.key_down}, 32'd0);
        check("arst_num", {16'd0, kp.num}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        model_num = 16'h0;
        expect_key(4'd3, 1'b0);
        cycles(47);
        check("arst_fresh_early", {31'd0, kp.key_down}, 32'd0);
        cycles(1);
        check("arst_fresh_down", {31'd0, kp.key_down}, 32'd1);
        check("arst_fresh_code", {28'd0, kp.key_code}, 32'd3);
        keys = 16'h0;
        cycles(64);
        check("final_pulses", pulses, exp_pulses);
        check("final_queue", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Input-side counterpart of the board's multiplexed 7-segment display scanner: drives a 4x4 key matrix one row at a time (active-low, one-hot, like the anode scan), senses the columns, debounces, and emits one hex key code per accepted press. Accepted codes are also shifted into a 16-bit register whose layout matches the display's `num` input, so typed digits can be shown directly.

## Interface
- `DIV_BITS`, default 17: prescaler width; a row is driven for 2^DIV_BITS cycles (1.31 ms at 100 MHz).
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full scans required to accept a press or release; legal range is 2..15.
- `clk_100mhz`  in  1  system clock.
- `RSTN`  in  1  reset; asynchronous, active-low.
- `COL`  in  4  column sense, active-low (pulled up off-chip), asynchronous to the clock.
- `clr`  in  1  synchronous clear of `num`.
- `ROW`  out  4  row drive, active-low one-hot.
- `key_code`  out  4  code of the last accepted key: row*4 + col.
- `key_valid`  out  1  one-cycle pulse per accepted press.
- `key_down`  out  1  high from acceptance until the release is debounced.
- `num`  out  16  last four accepted codes; newest in `[3:0]`.

## Operation
- **Column sync:** `COL` passes through a 2-FF synchronizer. Only synchronized values are used.
- **Prescaler:** a `DIV_BITS`-bit counter free-runs. `tick` is asserted when the counter is all-ones, after which it wraps to 0.
- **Row index:** `r` (2 bits) advances on `tick` and wraps 3→0. `ROW = ~(4'b1 << r)`.
- **Row sampling:** on each `tick`, the synchronized columns for the current `r` are sampled before `r` advances.
  - A row hit is any column bit low; its column is the lowest-index low bit.
  - The scan result keeps the first hit in row order 0→3. Lowest row wins, then lowest column.
- **End of scan:** a scan ends on the `tick` with r==3. At that point the scan result (`found`, `code`) is evaluated by the FSM below, then the scan accumulator is cleared.
- **FSM states** (5-bit `cnt`, `cand` register):
  - **IDLE:**
    - found → `cand`=code, `cnt`=1, go to DEBOUNCE.
  - **DEBOUNCE:**
    - found, code==`cand` → `cnt`++. If `cnt`+1 == `DEBOUNCE_SCANS`: `key_code`=`cand`, pulse `key_valid`, `key_down`=1, `num`={`num[11:0]`,`cand`}, go to PRESSED.
    - found, code!=`cand` → `cand`=code, `cnt`=1, stay.
    - not found → go to IDLE.
  - **PRESSED:**
    - not found → `cnt`=1, go to RELEASE.
    - found (any code, including a different key) → stay. No auto-repeat.
  - **RELEASE:**
    - not found → `cnt`++. If `cnt`+1 == `DEBOUNCE_SCANS`: `key_down`=0, go to IDLE.
    - found → go to PRESSED.
- **clr:** `num` ← 0 on the next edge. If `clr` coincides with an acceptance, `clr` wins for `num`; `key_code`, `key_valid` and `key_down` still update normally.
- **Reset (async, any time, including mid-debounce):**
  - Prescaler=0, `r`=0, `ROW`=4'b1110, FSM in IDLE, `cnt`=0, `cand`=0.
  - `key_code`=0, `key_valid`=0, `key_down`=0, `num`=0.
  - Synchronizer flops reset to 4'b1111.

## Timing
- Scan period: 4·2^DIV_BITS cycles.
- Synchronizer latency: 2 cycles. This is negligible against the row dwell, so rows are sampled fully settled.
- `key_valid`, `key_code`, `num` and `key_down` all change on the edge after the end-of-scan `tick` of the `DEBOUNCE_SCANS`-th consecutive matching scan.
- `key_valid` is high for exactly 1 cycle.
- Press-to-accept latency: from `DEBOUNCE_SCANS`−1 to `DEBOUNCE_SCANS` scan periods, depending on press phase.
- Release-to-`key_down` low: same bound.
- All outputs are registered. There are no combinational paths from `COL` to outputs.

## Test plan
The bench uses `DIV_BITS`=2 (4-cycle dwell, 16-cycle scan) and `DEBOUNCE_SCANS`=3. The matrix model drives `COL[c]` low whenever `ROW[r]`=0 and key (r,c) is pressed.
- **Reset mid-operation:** assert `RSTN` low in DEBOUNCE with a key held → `ROW`=1110 and all outputs 0 immediately (asynchronously). After release of reset, acceptance requires 3 fresh scans.
- **Single press:** hold key (2,1) → exactly one `key_valid` pulse with `key_code`=9, `num`=0x0009, `key_down`=1. No further pulses over 10 scans held. After release, `key_down` goes 0 after 3 empty scans.
- **Digit entry:** press and release keys 1, 2, 3, 4, 5 in sequence → `num`=0x2345 and exactly 5 pulses.
- **Bounce:** key (0,0) pressed for 1 scan, released for 1 scan, pressed for 1 scan → no `key_valid`. Candidate switch from key 3 to key 6 mid-debounce → accepted code is 6 only after 3 scans of 6.
- **Simultaneous keys:** hold (1,3) and (2,0) together → `key_code`=7. Adding a second key while in PRESSED produces no new pulse.
- **clr:** `clr` in an idle cycle → `num`=0x0000 on the next edge. `clr` in the same cycle as an acceptance of key A → `num`=0x0000, `key_code`=0xA, `key_valid` pulses.
